vec_lane_shifter: RTL and testbench
===================================

Name: vec_lane_shifter

Overview:
- Pipelined, parametrised SIMD lane shifter.
- Splits a packed vector into LANES independent lanes of LANE_W bits each, and applies a run-time shift amount and mode to every enabled lane.
- Sits between the vector register file and the fixed-point scaling path. It generalises the fixed per-lane right-shift-by-8 scaler.
- Uses a valid/ready handshake and sustains one vector per cycle.

Parameters:
- LANES, 8, number of lanes.
- LANE_W, 16, bits per lane (power of two, ≥4).
- SHAMT_W, $clog2(LANE_W)+1, shift-amount width; encodes 0..2*LANE_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  LANES*LANE_W  packed lanes; lane i = in_data[i*LANE_W +: LANE_W].
- in_shamt  in  SHAMT_W  shift amount, common to all lanes.
- in_mode  in  2  operation: 0 logical right, 1 arithmetic right, 2 logical left, 3 rotate right.
- in_mask  in  LANES  1 = lane shifted, 0 = lane passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  LANES*LANE_W  shifted lanes.
- out_ovf  out  LANES  per-lane flag: a nonzero bit was shifted out (modes 0/1/2; always 0 for rotate or masked lanes).

Behaviour:
- Reset (async, any time, mid-transfer included):
  - s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_ovf=0, in_ready=1 on the first cycle after release.
  - In-flight vectors are discarded.
- Pipeline: two register stages, latency 2 cycles from accept to out_valid when unstalled.
  - S1 registers data, shamt, mode and mask.
  - S2 registers the computed result and ovf.
- Handshake:
  - Transfer occurs when valid && ready.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, combinational from out_ready; no combinational path from in_valid to in_ready.
  - While out_valid && !out_ready: out_data and out_ovf hold stable and out_valid stays 1.
  - Full throughput: back-to-back accepts with out_ready held 1.
  - Simultaneous accept and emit in the same cycle is legal and loses nothing.
- Shift rules per lane, x = lane value, s = shamt:
  - Mode 0: x >> s, zero fill; s ≥ LANE_W gives 0.
  - Mode 1: sign-fill right shift; s ≥ LANE_W gives all copies of x[LANE_W-1].
  - Mode 2: x << s; s ≥ LANE_W gives 0.
  - Mode 3: rotate right by s mod LANE_W.
  - s = 0: lane unchanged, ovf=0.
  - Lane with mask bit 0: output = input, ovf=0.
- ovf: OR of all bits discarded off the lane edge (mode 2: upper bits; modes 0/1: lower bits).
- Legacy equivalence: LANES=8, LANE_W=16, mode 0, shamt 8, mask all ones reproduces the old fixed scaler exactly.

Optional Feature:
- Macro VEC_SHIFT_ROUND_EN.
- Defined:
  - Modes 0 and 1 round half-up: add bit x[s-1] to the shifted result (when 1 ≤ s ≤ LANE_W).
  - The result wraps within LANE_W. Mode 1 at max positive cannot overflow because the shift reduces magnitude.
  - ovf semantics are unchanged.
  - Adds no latency.
- Undefined: pure truncation; the rounding adder is not built.

Decomposition:
- Package vec_shift_pkg:
  - shift_mode_e enum: SH_LSR=0, SH_ASR=1, SH_LSL=2, SH_ROR=3.
  - Localparam defaults for LANES and LANE_W.
  - Helper function lane_slice.
- One combinational sub-module, lane_shift: single-lane shift, ovf and optional round, parametrised by LANE_W.
- vec_lane_shifter instantiates LANES copies of lane_shift via generate, and owns the pipeline and handshake.

Test Plan:
- Legacy: lane0=16'h1234, lane7=16'hABCD, mode 0, shamt 8, mask FF → lane0=16'h0012, lane7=16'h00AB, ovf lane0=1, ovf lane7=1, out_valid exactly 2 cycles after accept.
- Arithmetic/left: lane=16'h8001, mode 1, shamt 4 → 16'hF800, ovf=1; mode 2, shamt 1 → 16'h0002, ovf=1.
- Boundaries: lane=16'h8000.
  - Mode 1, shamt 16 → 16'hFFFF.
  - Mode 0, shamt 16 → 16'h0000, ovf=1.
  - Mode 3, shamt 20 → 16'h0800.
  - Mode 0, shamt 0 → 16'h8000, ovf=0.
  - mask bit 0 → 16'h8000, ovf=0.
- Backpressure: stream 6 vectors and hold out_ready=0 for 3 cycles after the first result → in_ready drops once both stages are full, out_data stays stable, all 6 results emerge in order, none lost or duplicated.
- Reset mid-stream: assert rst asynchronously with 2 vectors in flight → out_valid=0 immediately, out_data=0; after release in_ready=1 and no stale output appears.
- With VEC_SHIFT_ROUND_EN: lane=16'h0180, mode 0, shamt 8 → 16'h0002 (16'h0001 without the macro); lane=16'hFF7F, mode 1, shamt 8 → 16'hFFFF.

Source files
------------

// File: rtl/vec_shift_pkg.sv
// vec_shift_pkg: shared mode encoding, default geometry and lane offset helper for vec_lane_shifter
package vec_shift_pkg;
    typedef enum logic [1:0] {
        SH_LSR = 2'd0,
        SH_ASR = 2'd1,
        SH_LSL = 2'd2,
        SH_ROR = 2'd3
    } shift_mode_e;
    localparam int LANES_DEF = 8;
    localparam int LANE_W_DEF = 16;
    function automatic int lane_slice(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction
endpackage

// File: rtl/lane_shift.sv
// lane_shift: single-lane shift with discarded-bit flag; VEC_SHIFT_ROUND_EN adds round half-up to right shifts
module lane_shift
    import vec_shift_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int SHAMT_W = $clog2(LANE_W) + 1
) (
    input  logic [LANE_W-1:0]  x,
    input  logic [SHAMT_W-1:0] s,
    input  shift_mode_e        mode,
    input  logic               en,
    output logic [LANE_W-1:0]  y,
    output logic               ovf
);
    logic big;
    logic [SHAMT_W-2:0] sl;
    logic [LANE_W-1:0] lsr, asr, lsl, ror, lo_mask, hi_mask, base, res;
    // MSB of the shift amount set means the whole lane is shifted away
    assign big = s[SHAMT_W-1];
    assign sl = s[SHAMT_W-2:0];
    assign lsr = big ? '0 : x >> sl;
    assign asr = big ? {LANE_W{x[LANE_W-1]}} : LANE_W'($signed(x) >>> sl);
    assign lsl = big ? '0 : x << sl;
    assign ror = (x >> sl) | (x << (LANE_W - int'(sl)));
    assign lo_mask = big ? '1 : ~({LANE_W{1'b1}} << sl);
    assign hi_mask = big ? '1 : ~({LANE_W{1'b1}} >> sl);
    assign base = mode == SH_LSR ? lsr : mode == SH_ASR ? asr : mode == SH_LSL ? lsl : ror;
`ifdef VEC_SHIFT_ROUND_EN
    logic [LANE_W-1:0] rsel;
    logic rbit;
    assign rsel = (s != '0 && s <= SHAMT_W'(LANE_W)) ? LANE_W'(1) << (s - SHAMT_W'(1)) : '0;
    assign rbit = |(x & rsel);
    assign res = base + LANE_W'(rbit & ~mode[1]);
`else
    assign res = base;
`endif
    assign y = (!en || s == '0) ? x : res;
    assign ovf = en && s != '0 && mode != SH_ROR && |(x & (mode == SH_LSL ? hi_mask : lo_mask));
endmodule

// File: rtl/vec_lane_shifter.sv
// vec_lane_shifter: two-stage valid/ready SIMD lane shifter; VEC_SHIFT_ROUND_EN enables rounding in lane_shift
module vec_lane_shifter
    import vec_shift_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int SHAMT_W = $clog2(LANE_W) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*LANE_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0]       in_shamt,
    input  logic [1:0]               in_mode,
    input  logic [LANES-1:0]         in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*LANE_W-1:0]  out_data,
    output logic [LANES-1:0]         out_ovf
);
    logic s1_valid, s2_valid, adv1, adv2;
    logic [LANES*LANE_W-1:0] s1_data, res;
    logic [SHAMT_W-1:0] s1_shamt;
    shift_mode_e s1_mode;
    logic [LANES-1:0] s1_mask, ovf;
    assign adv2 = !s2_valid || out_ready;
    assign adv1 = !s1_valid || adv2;
    assign in_ready = adv1;
    assign out_valid = s2_valid;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_shift #(.LANE_W(LANE_W), .SHAMT_W(SHAMT_W)) u_lane (
            .x(s1_data[lane_slice(i, LANE_W) +: LANE_W]),
            .s(s1_shamt),
            .mode(s1_mode),
            .en(s1_mask[i]),
            .y(res[lane_slice(i, LANE_W) +: LANE_W]),
            .ovf(ovf[i])
        );
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data <= '0;
            s1_shamt <= '0;
            s1_mode <= SH_LSR;
            s1_mask <= '0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_ovf <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_shamt <= in_shamt;
                    s1_mode <= shift_mode_e'(in_mode);
                    s1_mask <= in_mask;
                end
            end
            // output register only moves on a real result so out_data stays clean while idle
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= res;
                    out_ovf <= ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_lane_shifter.sv
// tb_vec_lane_shifter: table vectors, random scoreboard, backpressure and async reset checks
module tb_vec_lane_shifter;
    localparam int NL = 8;
    localparam int LW = 16;
    localparam int SW = 5;
    localparam int DW = NL * LW;
`ifdef VEC_SHIFT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    logic clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [SW-1:0] in_shamt;
    logic [1:0] in_mode;
    logic [NL-1:0] in_mask, out_ovf;
    vec_lane_shifter #(.LANES(NL), .LANE_W(LW), .SHAMT_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode), .in_mask(in_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [1:0] m;
        logic [NL-1:0] k;
        logic [DW-1:0] ey;
        logic [NL-1:0] eo;
    } tv_t;
    typedef struct {
        logic [DW-1:0] y;
        logic [NL-1:0] o;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int n_chk = 0;
    int n_fail = 0;
    int n_out = 0;
    bit rnd_done;
    tv_t tv[11];
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic void ref_lane(input longint x, input int s, input int m, output longint y, output bit ov);
        longint d, full, v, q, r;
        full = longint'(1) << LW;
        d = longint'(1) << s;
        ov = 0;
        y = x;
        if (s == 0) return;
        case (m)
            0: begin
                y = x / d;
                ov = (x % d) != 0;
            end
            1: begin
                v = x >= full / 2 ? x - full : x;
                q = v / d;
                if (v % d != 0 && v < 0) q = q - 1;
                y = q < 0 ? q + full : q;
                ov = (v % d) != 0;
            end
            2: begin
                y = (x * d) % full;
                ov = (x * d) / full != 0;
            end
            default: begin
                r = s % LW;
                y = (x / (longint'(1) << r) + x * (longint'(1) << (LW - r))) % full;
            end
        endcase
        if (RND && m < 2 && s <= LW) y = (y + (x / (d / 2)) % 2) % full;
    endfunction
    function automatic exp_t ref_vec(input logic [DW-1:0] d, input int s, input int m, input logic [NL-1:0] k);
        exp_t e;
        longint yl;
        bit ov;
        for (int i = 0; i < NL; i++) begin
            if (k[i]) ref_lane(longint'(d[i*LW +: LW]), s, m, yl, ov);
            else begin
                yl = longint'(d[i*LW +: LW]);
                ov = 0;
            end
            e.y[i*LW +: LW] = yl[LW-1:0];
            e.o[i] = ov;
        end
        return e;
    endfunction
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("sb_unexpected_output", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_data", out_data, mon_e.y);
                    chk("sb_ovf", out_ovf, mon_e.o);
                end
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_vec(in_data, int'(in_shamt), int'(in_mode), in_mask));
        end
    end
    // called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic push_vec(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [1:0] m, input logic [NL-1:0] k);
        int n;
        bit acc;
        in_valid = 1;
        in_data = d;
        in_shamt = s;
        in_mode = m;
        in_mask = k;
        n = 0;
        acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("push_timeout", 0, 1);
        in_valid = 0;
    endtask
    task automatic drain();
        int n;
        out_ready = 1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask
    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int base;
        int k;
        logic [DW-1:0] held;
        clk = 0;
        rst = 1;
        in_valid = 0;
        in_data = '0;
        in_shamt = '0;
        in_mode = '0;
        in_mask = '0;
        out_ready = 1;
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_ovf", out_ovf, 0);
        #9 rst = 0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        tv[0] = '{d: {16'hABCD, 96'h0, 16'h1234}, s: 5'd8, m: 2'd0, k: 8'hFF,
                  ey: {(RND ? 16'h00AC : 16'h00AB), 96'h0, 16'h0012}, eo: 8'h81};
        tv[1] = '{d: {112'h0, 16'h8001}, s: 5'd4, m: 2'd1, k: 8'hFF, ey: {112'h0, 16'hF800}, eo: 8'h01};
        tv[2] = '{d: {112'h0, 16'h8001}, s: 5'd1, m: 2'd2, k: 8'hFF, ey: {112'h0, 16'h0002}, eo: 8'h01};
        tv[3] = '{d: {112'h0, 16'h8000}, s: 5'd16, m: 2'd1, k: 8'hFF, ey: {112'h0, (RND ? 16'h0000 : 16'hFFFF)}, eo: 8'h01};
        tv[4] = '{d: {112'h0, 16'h8000}, s: 5'd16, m: 2'd0, k: 8'hFF, ey: {112'h0, (RND ? 16'h0001 : 16'h0000)}, eo: 8'h01};
        tv[5] = '{d: {112'h0, 16'h8000}, s: 5'd20, m: 2'd3, k: 8'hFF, ey: {112'h0, 16'h0800}, eo: 8'h00};
        tv[6] = '{d: {112'h0, 16'h8000}, s: 5'd0, m: 2'd0, k: 8'hFF, ey: {112'h0, 16'h8000}, eo: 8'h00};
        tv[7] = '{d: {112'h0, 16'h8000}, s: 5'd4, m: 2'd0, k: 8'hFE, ey: {112'h0, 16'h8000}, eo: 8'h00};
        tv[8] = '{d: {112'h0, 16'h0180}, s: 5'd8, m: 2'd0, k: 8'hFF, ey: {112'h0, (RND ? 16'h0002 : 16'h0001)}, eo: 8'h01};
        tv[9] = '{d: {112'h0, 16'hFF7F}, s: 5'd8, m: 2'd1, k: 8'hFF, ey: {112'h0, 16'hFFFF}, eo: 8'h01};
        tv[10] = '{d: {80'h0, 16'h00F0, 32'h0}, s: 5'd12, m: 2'd2, k: 8'hFF, ey: {128'h0}, eo: 8'h04};
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            push_vec(tv[i].d, tv[i].s, tv[i].m, tv[i].k);
            @(negedge clk);
            chk($sformatf("tv%0d_latency_early", i), out_valid, 0);
            @(negedge clk);
            chk($sformatf("tv%0d_latency_valid", i), out_valid, 1);
            chk($sformatf("tv%0d_data", i), out_data, tv[i].ey);
            chk($sformatf("tv%0d_ovf", i), out_ovf, tv[i].eo);
            @(posedge clk);
            #1;
        end
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) push_vec(rnd_data(), SW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 8'($urandom));
            end
            begin
                k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (!out_valid && k < 50);
                chk("bp_first_result", out_valid, 1);
                held = out_data;
                out_ready = 0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("bp_hold_valid", out_valid, 1);
                    chk("bp_hold_data", out_data, held);
                end
                chk("bp_in_ready_low", in_ready, 0);
                out_ready = 1;
            end
        join
        drain();
        chk("bp_result_count", n_out - base, 6);
        base = n_out;
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    push_vec(rnd_data(), SW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 8'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = $urandom_range(0, 2) != 0;
                end
            end
        join
        drain();
        chk("rnd_result_count", n_out - base, 300);
        out_ready = 0;
        push_vec(rnd_data(), 5'd3, 2'd0, 8'hFF);
        push_vec(rnd_data(), 5'd5, 2'd2, 8'hFF);
        #2 rst = 1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_data", out_data, 0);
        chk("rst_mid_out_ovf", out_ovf, 0);
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("rst_rel_in_ready", in_ready, 1);
        chk("rst_rel_out_valid", out_valid, 0);
        #1 out_ready = 1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_stale_output", out_valid, 0);
        end
        chk("rst_queue_flushed", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
